// File: rtl/localbus_cfg_arbiter.sv
// localbus_cfg_arbiter: round-robin localbus master for the host config
// and rule-loader requesters; one ALE/CS/ACK bus cycle per grant.
module localbus_cfg_arbiter #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req0_rd,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_done,
  output logic        req0_err,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_rd,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_done,
  output logic        req1_err,
  output logic [31:0] req1_rdata,
  output logic        localbus_ale,
  output logic        localbus_cs_n,
  output logic        localbus_rd_wr,
  output logic [31:0] localbus_data,
  input  logic        localbus_ack_n,
  input  logic [31:0] localbus_data_in
);

  typedef enum logic [1:0] {IDLE, ALE, WAIT_ACK, RELEASE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_d;
  logic        rr_last, rr_last_d;
  logic        win, win_d;
  logic        lat_rd, lat_rd_d;
  logic [31:0] lat_wdata, lat_wdata_d;
  logic [15:0] cnt, cnt_d;
  logic        ale_d, cs_n_d, rd_wr_d;
  logic [31:0] data_d;
  logic [1:0]  done, done_d;
  logic [1:0]  err, err_d;
  logic [31:0] rdata0_d, rdata1_d;

  logic        any_req, grant, ack, tmo_hit;
  logic [31:0] rd_val;

  // grant goes to the requester after rr_last when it is asking
  assign any_req = req0_valid | req1_valid;
  assign grant   = rr_last ? ~req0_valid : req1_valid;
  assign ack     = ~localbus_ack_n;
  assign tmo_hit = cnt == TMO_LAST;
  assign rd_val  = (ack && lat_rd) ? localbus_data_in : '0;

  assign req0_done = done[0];
  assign req1_done = done[1];
  assign req0_err  = err[0];
  assign req1_err  = err[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (any_req) state_d = ALE;
      ALE:      state_d = WAIT_ACK;
      WAIT_ACK: if (ack || tmo_hit) state_d = RELEASE;
      RELEASE:  if (!ack) state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_last_d   = rr_last;
    win_d       = win;
    lat_rd_d    = lat_rd;
    lat_wdata_d = lat_wdata;
    cnt_d       = cnt;
    ale_d       = 1'b0;
    cs_n_d      = localbus_cs_n;
    rd_wr_d     = localbus_rd_wr;
    data_d      = localbus_data;
    done_d      = '0;
    err_d       = '0;
    rdata0_d    = req0_rdata;
    rdata1_d    = req1_rdata;
    unique case (state)
      IDLE: begin
        rd_wr_d = 1'b1;
        if (any_req) begin
          win_d       = grant;
          rr_last_d   = grant;
          lat_rd_d    = grant ? req1_rd : req0_rd;
          lat_wdata_d = grant ? req1_wdata : req0_wdata;
          ale_d       = 1'b1;
          rd_wr_d     = lat_rd_d;
          data_d      = grant ? req1_addr : req0_addr;
        end
      end
      ALE: begin
        cs_n_d = 1'b0;
        data_d = lat_rd ? '0 : lat_wdata;
        cnt_d  = '0;
      end
      WAIT_ACK: begin
        // an ack arriving on the last timeout cycle still counts as success
        if (ack || tmo_hit) begin
          cs_n_d      = 1'b1;
          data_d      = '0;
          done_d[win] = 1'b1;
          err_d[win]  = ~ack;
          if (win) rdata1_d = rd_val;
          else     rdata0_d = rd_val;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      RELEASE: begin
        data_d = '0;
        if (!ack) rd_wr_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last        <= 1'b1;
      win            <= 1'b0;
      lat_rd         <= 1'b0;
      lat_wdata      <= '0;
      cnt            <= '0;
      localbus_ale   <= 1'b0;
      localbus_cs_n  <= 1'b1;
      localbus_rd_wr <= 1'b1;
      localbus_data  <= '0;
      done           <= '0;
      err            <= '0;
      req0_rdata     <= '0;
      req1_rdata     <= '0;
    end else begin
      rr_last        <= rr_last_d;
      win            <= win_d;
      lat_rd         <= lat_rd_d;
      lat_wdata      <= lat_wdata_d;
      cnt            <= cnt_d;
      localbus_ale   <= ale_d;
      localbus_cs_n  <= cs_n_d;
      localbus_rd_wr <= rd_wr_d;
      localbus_data  <= data_d;
      done           <= done_d;
      err            <= err_d;
      req0_rdata     <= rdata0_d;
      req1_rdata     <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_localbus_cfg_arbiter.sv
// tb_localbus_cfg_arbiter: directed requests, slave model, and
// scoreboard monitors for the localbus arbiter.
module tb_localbus_cfg_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_rd, req0_done, req0_err;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_rd, req1_done, req1_err;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        localbus_ale, localbus_cs_n, localbus_rd_wr;
  logic [31:0] localbus_data;
  logic        localbus_ack_n;
  logic [31:0] localbus_data_in;

  localbus_cfg_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0_valid(req0_valid),
    .req0_rd(req0_rd),
    .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req0_done(req0_done),
    .req0_err(req0_err),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid),
    .req1_rd(req1_rd),
    .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .req1_done(req1_done),
    .req1_err(req1_err),
    .req1_rdata(req1_rdata),
    .localbus_ale(localbus_ale),
    .localbus_cs_n(localbus_cs_n),
    .localbus_rd_wr(localbus_rd_wr),
    .localbus_data(localbus_data),
    .localbus_ack_n(localbus_ack_n),
    .localbus_data_in(localbus_data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [31:0] wdata;
    int          cs_len;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  int          slv_delay = 0;
  int          slv_hold  = 0;
  bit          slv_noack = 1'b0;
  logic [31:0] slv_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic void push_bus(input logic [31:0] addr, input logic rd,
                                   input logic [31:0] wdata, input int cs_len);
    bus_t b;
    b.addr   = addr;
    b.rd     = rd;
    b.wdata  = wdata;
    b.cs_len = cs_len;
    bus_q.push_back(b);
  endfunction

  function automatic void push_resp(input int id, input logic err,
                                    input logic [31:0] rdata);
    resp_t r;
    r.id    = id;
    r.err   = err;
    r.rdata = rdata;
    resp_q.push_back(r);
  endfunction

  task automatic start_req(input int id, input logic rd,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (id == 0) begin
      req0_rd = rd; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
    end else begin
      req1_rd = rd; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_done(input int id);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = (id == 0) ? req0_done : req1_done;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout_req%0d: got no done want done in 300 cycles", id);
    end
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic gap_to_ale(input int want, input string name);
    int gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!localbus_ale && gap < 50);
    chk(name, 32'(gap), 32'(want));
  endtask

  task automatic wait_cs_low();
    int n = 0;
    while (localbus_cs_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cs_low_seen", 32'(localbus_cs_n), 32'd0);
  endtask

  // slave: ack after slv_delay CS cycles, hold ack slv_hold cycles past CS
  initial begin
    int cs_cnt;
    int hold_cnt;
    cs_cnt = 0;
    hold_cnt = 0;
    localbus_ack_n = 1'b1;
    localbus_data_in = 32'h0;
    forever begin
      @(negedge clk);
      if (localbus_ack_n && !localbus_cs_n && !slv_noack) begin
        if (cs_cnt == slv_delay) begin
          localbus_ack_n = 1'b0;
          localbus_data_in = slv_rdata;
          hold_cnt = 0;
        end else begin
          cs_cnt++;
        end
      end else if (!localbus_ack_n && localbus_cs_n) begin
        if (hold_cnt == slv_hold) begin
          localbus_ack_n = 1'b1;
          localbus_data_in = 32'h0;
          cs_cnt = 0;
        end else begin
          hold_cnt++;
        end
      end else if (localbus_ack_n && localbus_cs_n) begin
        cs_cnt = 0;
      end
    end
  end

  initial begin
    resp_t x;
    logic  d, e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        d = (id == 0) ? req0_done : req1_done;
        e = (id == 0) ? req0_err : req1_err;
        r = (id == 0) ? req0_rdata : req1_rdata;
        if (d) begin
          if (resp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done on req%0d want none", id);
          end else begin
            x = resp_q.pop_front();
            chk("grant_id", 32'(id), 32'(x.id));
            chk("done_err", 32'(e), 32'(x.err));
            chk("done_rdata", r, x.rdata);
          end
        end
      end
    end
  end

  initial begin
    bus_t cur;
    int   cs_cnt;
    cs_cnt = 0;
    cur = '{addr: 32'h0, rd: 1'b0, wdata: 32'h0, cs_len: -1};
    forever begin
      @(negedge clk);
      if (localbus_ale) begin
        if (bus_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ale: got ale addr %h want none", localbus_data);
        end else begin
          cur = bus_q.pop_front();
          chk("ale_addr", localbus_data, cur.addr);
          chk("ale_rd_wr", 32'(localbus_rd_wr), 32'(cur.rd));
          chk("ale_cs_n", 32'(localbus_cs_n), 32'd1);
        end
      end
      if (!localbus_cs_n) begin
        if (cs_cnt == 0) begin
          chk("cs_data", localbus_data, cur.rd ? 32'h0 : cur.wdata);
          chk("cs_rd_wr", 32'(localbus_rd_wr), 32'(cur.rd));
        end
        cs_cnt++;
      end else if (cs_cnt > 0) begin
        if (cur.cs_len >= 0) chk("cs_len", 32'(cs_cnt), 32'(cur.cs_len));
        chk("bus_data_idle", localbus_data, 32'h0);
        cs_cnt = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_rd = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_rd = 1'b0; req1_addr = '0; req1_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ale", 32'(localbus_ale), 32'd0);
    chk("rst_cs_n", 32'(localbus_cs_n), 32'd1);
    chk("rst_rd_wr", 32'(localbus_rd_wr), 32'd1);
    chk("rst_data", localbus_data, 32'h0);
    chk("rst_done", 32'({req1_done, req0_done}), 32'd0);
    chk("rst_err", 32'({req1_err, req0_err}), 32'd0);
    chk("rst_rdata0", req0_rdata, 32'h0);
    chk("rst_rdata1", req1_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // write, slave acks on the third CS cycle
    slv_delay = 2;
    push_bus(32'h0010_0004, 1'b0, 32'hDEAD_BEEF, 3);
    push_resp(0, 1'b0, 32'h0);
    start_req(0, 1'b0, 32'h0010_0004, 32'hDEAD_BEEF);
    wait_done(0);
    chk("rd_wr_held", 32'(localbus_rd_wr), 32'd0);

    // read issued on the done cycle, immediate ack
    slv_delay = 0;
    slv_rdata = 32'h1234_5678;
    push_bus(32'h0000_0020, 1'b1, 32'h0, 1);
    push_resp(1, 1'b0, 32'h1234_5678);
    start_req(1, 1'b1, 32'h0000_0020, 32'h0);
    gap_to_ale(2, "turnaround_gap");
    wait_done(1);
    repeat (2) @(negedge clk);
    chk("idle_cs_n", 32'(localbus_cs_n), 32'd1);
    chk("idle_data", localbus_data, 32'h0);
    chk("idle_rd_wr", 32'(localbus_rd_wr), 32'd1);

    // both requesters contend and re-request: grants alternate 0,1,0,1
    slv_delay = 1;
    slv_rdata = 32'h0BAD_F00D;
    push_bus(32'h0010_0100, 1'b0, 32'hA5A5_0001, 2);
    push_resp(0, 1'b0, 32'h0);
    push_bus(32'h0000_0040, 1'b1, 32'h0, 2);
    push_resp(1, 1'b0, 32'h0BAD_F00D);
    push_bus(32'h0010_0104, 1'b1, 32'h0, 2);
    push_resp(0, 1'b0, 32'h0BAD_F00D);
    push_bus(32'h0000_0044, 1'b0, 32'h5A5A_0002, 2);
    push_resp(1, 1'b0, 32'h0);
    start_req(0, 1'b0, 32'h0010_0100, 32'hA5A5_0001);
    start_req(1, 1'b1, 32'h0000_0040, 32'h0);
    fork
      begin
        wait_done(0);
        start_req(0, 1'b1, 32'h0010_0104, 32'h0);
        wait_done(0);
      end
      begin
        wait_done(1);
        start_req(1, 1'b0, 32'h0000_0044, 32'h5A5A_0002);
        wait_done(1);
      end
    join
    repeat (2) @(negedge clk);

    // no ack: abort after TMO wait cycles, then next request served
    slv_noack = 1'b1;
    push_bus(32'h0010_0200, 1'b1, 32'h0, TMO);
    push_resp(0, 1'b1, 32'h0);
    start_req(0, 1'b1, 32'h0010_0200, 32'h0);
    wait_done(0);
    slv_noack = 1'b0;
    slv_delay = 0;
    push_bus(32'h0000_0080, 1'b0, 32'h1122_3344, 1);
    push_resp(1, 1'b0, 32'h0);
    start_req(1, 1'b0, 32'h0000_0080, 32'h1122_3344);
    wait_done(1);
    repeat (2) @(negedge clk);

    // slave holds ack 5 cycles past CS: next ALE waits for release
    slv_hold = 5;
    slv_rdata = 32'hFEED_C0DE;
    push_bus(32'h0010_0300, 1'b0, 32'h0102_0304, 1);
    push_resp(0, 1'b0, 32'h0);
    push_bus(32'h0010_0304, 1'b1, 32'h0, 1);
    push_resp(0, 1'b0, 32'hFEED_C0DE);
    start_req(0, 1'b0, 32'h0010_0300, 32'h0102_0304);
    wait_done(0);
    start_req(0, 1'b1, 32'h0010_0304, 32'h0);
    gap_to_ale(7, "ack_hold_gap");
    wait_done(0);
    repeat (8) @(negedge clk);
    slv_hold = 0;

    // reset during WAIT_ACK, then contention from a clean start
    slv_noack = 1'b1;
    push_bus(32'h0010_0400, 1'b0, 32'h9999_9999, -1);
    start_req(0, 1'b0, 32'h0010_0400, 32'h9999_9999);
    wait_cs_low();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cs_n", 32'(localbus_cs_n), 32'd1);
    chk("async_rst_ale", 32'(localbus_ale), 32'd0);
    chk("async_rst_data", localbus_data, 32'h0);
    chk("async_rst_done", 32'(req0_done), 32'd0);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    slv_noack = 1'b0;
    @(negedge clk);
    slv_rdata = 32'h7766_5544;
    push_bus(32'h0010_0404, 1'b1, 32'h0, 1);
    push_resp(0, 1'b0, 32'h7766_5544);
    push_bus(32'h0000_0084, 1'b1, 32'h0, 1);
    push_resp(1, 1'b0, 32'h7766_5544);
    start_req(0, 1'b1, 32'h0010_0404, 32'h0);
    start_req(1, 1'b1, 32'h0000_0084, 32'h0);
    fork
      wait_done(0);
      wait_done(1);
    join
    repeat (4) @(negedge clk);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
